// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: round-robin owner selection for the shared 4-digit
// seven-segment display, with a minimum ownership time before preemption.
// The owner's 6-bit value is forwarded to the display driver as num.
// Optional feature macro: SEG_ARB_LOCK_EN adds a lock input. While the owner
// holds lock high, preemption on hold expiry is suppressed.
module seg_display_arbiter #(
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int CNT_W       = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [23:0] val,
`ifdef SEG_ARB_LOCK_EN
    input  logic        lock,
`endif
    output logic [3:0]  gnt,
    output logic [5:0]  num,
    output logic        num_valid
);

    typedef enum logic {
        IDLE,
        OWN
    } state_e;

    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES);

    state_e           state_q, state_d;
    logic [1:0]       last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [5:0]       num_q, num_d;

    logic [5:0]       valArr [4];
    logic [3:0]       others;
    logic [1:0]       idleWin;
    logic [1:0]       handWin;
    logic             expired;
    logic             lockHold;

    // First set bit of mask, searching base+1, base+2, ... modulo 4.
    // Walks from the farthest candidate to the nearest so the nearest wins.
    function automatic logic [1:0] nextIdx(input logic [3:0] mask, input logic [1:0] base);
        logic [1:0] idx;
        nextIdx = base;
        for (int i = 4; i >= 1; i--) begin
            idx = base + 2'(i);
            if (mask[idx]) begin
                nextIdx = idx;
            end
        end
    endfunction

    for (genvar g = 0; g < 4; g++) begin : gVal
        assign valArr[g] = val[6*g +: 6];
    end

`ifdef SEG_ARB_LOCK_EN
    assign lockHold = lock;
`else
    assign lockHold = 1'b0;
`endif

    // In OWN, last_q is the owner index; "others" are requesters competing with it.
    assign others  = req & ~(4'b0001 << last_q);
    assign idleWin = nextIdx(req, last_q);
    assign handWin = nextIdx(others, last_q);
    assign expired = (cnt_q == HOLD_MAX);

    // Next-state logic: grant from idle, track the owner, release or hand over.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        num_d   = num_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = OWN;
                    last_d  = idleWin;
                    cnt_d   = '0;
                    gnt_d   = 4'b0001 << idleWin;
                    num_d   = valArr[idleWin];
                end
            end
            OWN: begin
                if (!req[last_q] || (expired && (|others) && !lockHold)) begin
                    if (|others) begin
                        last_d = handWin;
                        cnt_d  = '0;
                        gnt_d  = 4'b0001 << handWin;
                        num_d  = valArr[handWin];
                    end else begin
                        state_d = IDLE;
                        gnt_d   = 4'b0000;
                    end
                end else begin
                    cnt_d = expired ? cnt_q : cnt_q + CNT_W'(1);
                    num_d = valArr[last_q];
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
            end
        endcase
    end

    // State, pointer, hold counter and output registers; pointer resets to 3
    // so requester 0 gets first priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 2'd3;
            cnt_q   <= '0;
            gnt_q   <= 4'b0000;
            num_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            num_q   <= num_d;
        end
    end

    assign gnt       = gnt_q;
    assign num       = num_q;
    assign num_valid = (state_q == OWN);

endmodule

// File: doc/seg_display_arbiter.md
# seg_display_arbiter

Shares the board's single 4-digit seven-segment display between up to four requesters (game logic, debug counters, status codes). Arbitrates round-robin with a guaranteed minimum ownership time. Forwards the owner's 6-bit value as the `num` input of the seven-segment driver. Sits between the application datapaths and the display driver; the driver's scan logic is unchanged.

## Interface
- `HOLD_CYCLES`, default 50_000_000: minimum clk cycles a grant is kept while the owner still requests; minimum legal value 1.
- `CNT_W`, default 26: width of the hold counter; must satisfy 2^CNT_W > HOLD_CYCLES.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  4  request per requester; level-sensitive, held while display wanted.
- `val`  in  24  packed values; requester i drives `val[6*i+5:6*i]`, range 0..63.
- `gnt`  out  4  one-hot grant, all-zero when idle; registered.
- `num`  out  6  value to display driver; registered.
- `num_valid`  out  1  high while `gnt` non-zero; driver blanks when low.
- `lock`  in  1  present only with `SEG_ARB_LOCK_EN`; owner's request to extend ownership.

## Operation
- Two states: IDLE, OWN. Round-robin pointer `last` (2 bits) holds the index of the most recent owner.
- Reset: state IDLE, `gnt`=0, `num`=0, `num_valid`=0, `last`=3 (requester 0 has first priority), hold counter 0.
- IDLE: if any `req` bit is set, grant the first set bit searching `last+1`, `last+2`, … modulo 4. Go to OWN, load hold counter with 0, set `last` to the winner.
- OWN, owner index k:
  - Every cycle `num` <= `val[6k+5:6k]`. Live tracking; the value is not frozen at grant.
  - Hold counter increments, saturating at HOLD_CYCLES.
  - If `req[k]`=0: release. If other requests are pending, grant the next requester round-robin from k in the same edge, with no idle cycle between owners. Otherwise go to IDLE.
  - If `req[k]`=1, counter = HOLD_CYCLES, and another request is pending: hand over to the next round-robin requester, resetting the counter.
  - If `req[k]`=1 and no other request is pending: stay in OWN indefinitely.
- IDLE: `num` holds its last value and `num_valid`=0.
- Simultaneous requests are resolved by the pointer only; there is no fixed priority after the first grant.
- `val` bits of non-owners are ignored.
- Reset asserted mid-ownership: all outputs return to reset values immediately (asynchronously). The pointer returns to 3.

## Timing
- `req` rising in IDLE → `gnt`/`num_valid` high on the next rising edge (1-cycle latency). `num` carries the owner's value in that same cycle.
- Owner `val` change → `num` updates 1 cycle later.
- Owner drops `req` → `gnt` changes on the next edge (1 cycle).
- Preemption: with contention, the owner holds `gnt` for exactly HOLD_CYCLES+1 cycles, counted from the first cycle `gnt` is high.
- `gnt` is never multi-hot. `gnt` is never non-zero without `num_valid`=1.

## Configuration
- `SEG_ARB_LOCK_EN` defined:
  - Adds the `lock` input.
  - While the owner has `req[k]`=1 and `lock`=1, hold-expiry preemption is suppressed.
  - The counter keeps saturating.
  - Deasserting `lock` with the counter saturated and contention present hands over on the next edge.
  - Dropping `req[k]` still releases regardless of `lock`.
- Undefined: no `lock` port; preemption is purely time-based.

## Test plan
HOLD_CYCLES=4 for all scenarios.
- Reset then `req`=0001, `val[5:0]`=15 → one cycle later `gnt`=0001, `num`=15, `num_valid`=1. Owner `val` changed to 32 → `num`=32 one cycle later.
- `req`=1111 from IDLE after reset → grants cycle 0001, 0010, 0100, 1000, 0001, each held 5 cycles, with no gap cycles.
- Owner 0 holds with `req`=0001 for 20 cycles → `gnt` stays 0001. Then `req`=0101 → `gnt`=0100 exactly when counter saturates (cycle 5 of ownership, or next edge if already saturated).
- Owner 2 drops `req` after 2 cycles while `req[0]`=1 → `gnt`=0001 on the next edge. Then all `req`=0 → `gnt`=0, `num_valid`=0, `num` retains 60.
- `rst` pulsed mid-ownership → `gnt`=0, `num`=0, `num_valid`=0 without waiting for a clock edge. Next `req`=1010 → `gnt`=0010.
- With `SEG_ARB_LOCK_EN`: owner 1 with `lock`=1 and `req`=0011 for 12 cycles → no handover. `lock`=0 → `gnt`=0001 on the next edge.
